mb_rtu_poll_sched: RTL

Modbus RTU master poll scheduler. It owns a table of up to four read/write request slots and sequences the `mb_rtu_tx` frame transmitter. It serves the enabled slots round-robin and enforces the RTU inter-frame gap. It also tracks each response from the receive path, applying a timeout and bounded retries, and reports per-slot success or failure.

---
 rtl/mb_pkg.sv | 32 +++
 rtl/mb_slot_table.sv | 39 +++
 rtl/mb_rtu_poll_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// Shared types and constants for the Modbus RTU master poll path:
// FSM encoding, slot record layout, function codes and 50 MHz timing defaults.
package mb_pkg;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_GAP      = 6'b000010,
    ST_ISSUE    = 6'b000100,
    ST_WAIT_TX  = 6'b001000,
    ST_WAIT_RSP = 6'b010000,
    ST_NEXT     = 6'b100000
  } state_e;

  typedef struct packed {
    logic        en;
    logic [7:0]  fun;
    logic [15:0] addr;
    logic [15:0] num;
  } slot_t;

  localparam logic [7:0] FC_READ_COILS   = 8'h01;
  localparam logic [7:0] FC_READ_HOLD    = 8'h03;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;
  localparam logic [7:0] FC_WRITE_MULTI  = 8'h10;

  // T3.5 with 10-bit characters at a 50 MHz clock.
  localparam int GAP_9600      = 182292;
  localparam int GAP_19200     = 91146;
  localparam int TIMEOUT_9600  = 50000000;
  localparam int TIMEOUT_19200 = 50000000;

endpackage

// File: rtl/mb_slot_table.sv
// Request slot register file: one synchronous write port, one combinational
// read port, plus the enable vector that feeds the round-robin picker.
module mb_slot_table
  import mb_pkg::*;
#(
  parameter int SLOTS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(SLOTS)-1:0] wr_idx_i,
  input  slot_t                    wr_dat_i,
  input  logic [$clog2(SLOTS)-1:0] rd_idx_i,
  output slot_t                    rd_dat_o,
  output logic [SLOTS-1:0]         en_o
);

  slot_t tbl_q [SLOTS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SLOTS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (we_i) begin
      tbl_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = tbl_q[rd_idx_i];

  always_comb begin
    en_o = '0;
    for (int i = 0; i < SLOTS; i++) begin
      en_o[i] = tbl_q[i].en;
    end
  end

endmodule

// File: rtl/mb_rtu_poll_sched.sv
// Modbus RTU master poll scheduler: round-robin over enabled slots, inter-frame
// gap, response timeout and bounded retries, per-slot ok/fail status pulses.
module mb_rtu_poll_sched
  import mb_pkg::*;
#(
  parameter int SLOTS       = 4,
  parameter int GAP_CYC     = GAP_9600,
  parameter int TIMEOUT_CYC = TIMEOUT_9600,
  parameter int MAX_RETRY   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic                     cfg_we_i,
  input  logic [$clog2(SLOTS)-1:0] cfg_slot_i,
  input  logic                     cfg_en_i,
  input  logic [7:0]               cfg_fun_i,
  input  logic [15:0]              cfg_addr_i,
  input  logic [15:0]              cfg_num_i,
  input  logic                     tx_done_i,
  input  logic                     rx_done_i,
  input  logic                     rx_crc_ok_i,
  output logic                     tx_en_pulse_o,
  output logic [15:0]              mb_addr_o,
  output logic [15:0]              mb_num_o,
  output logic [7:0]               fun_o,
  output logic                     busy_o,
  output logic [$clog2(SLOTS)-1:0] cur_slot_o,
  output logic                     slot_ok_o,
  output logic                     slot_fail_o
);

  localparam int IW = $clog2(SLOTS);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e        state_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] cur_slot_q;
  logic [7:0]    fun_q;
  logic [15:0]   addr_q;
  logic [15:0]   num_q;
  logic          tx_en_q;
  logic          busy_q;
  logic          slot_ok_q;
  logic          slot_fail_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  slot_t            wr_dat;
  slot_t            rd_dat;
  logic [SLOTS-1:0] en_vec;
  logic             timer_hit;
  logic             ok_ev;
  logic             err_ev;
  logic             to_ev;

  assign wr_dat = '{en: cfg_en_i, fun: cfg_fun_i, addr: cfg_addr_i, num: cfg_num_i};

  mb_slot_table #(.SLOTS(SLOTS)) u_tbl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (cfg_we_i),
    .wr_idx_i (cfg_slot_i),
    .wr_dat_i (wr_dat),
    .rd_idx_i (pick_idx),
    .rd_dat_o (rd_dat),
    .en_o     (en_vec)
  );

  // Scan from the farthest offset down so the nearest enabled slot after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = SLOTS; i >= 1; i--) begin
      if (en_vec[rr_ptr_q + IW'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_ptr_q + IW'(i);
      end
    end
  end

  assign timer_hit = (timer_q >= TW'(TIMEOUT_CYC));
  assign ok_ev     = (state_q == ST_WAIT_RSP) && rx_done_i && rx_crc_ok_i;
  assign err_ev    = (state_q == ST_WAIT_RSP) && rx_done_i && !rx_crc_ok_i;
  // A response arriving on the timeout cycle takes priority over the timeout.
  assign to_ev     = timer_hit && (((state_q == ST_WAIT_TX) && !tx_done_i) ||
                                   ((state_q == ST_WAIT_RSP) && !rx_done_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      rr_ptr_q    <= IW'(SLOTS - 1);
      cur_slot_q  <= '0;
      fun_q       <= '0;
      addr_q      <= '0;
      num_q       <= '0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      slot_ok_q   <= 1'b0;
      slot_fail_q <= 1'b0;
    end else begin
      tx_en_q     <= 1'b0;
      slot_ok_q   <= 1'b0;
      slot_fail_q <= 1'b0;
      if (((state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RSP)) && !timer_hit) begin
        timer_q <= timer_q + 1'b1;
      end
      if (ok_ev) begin
        slot_ok_q <= 1'b1;
        state_q   <= ST_NEXT;
      end else if (err_ev || to_ev) begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_q <= retry_q + 1'b1;
          gap_q   <= '0;
          state_q <= ST_GAP;
        end else begin
          slot_fail_q <= 1'b1;
          state_q     <= ST_NEXT;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_i && pick_vld && rd_dat.en) begin
              cur_slot_q <= pick_idx;
              fun_q      <= rd_dat.fun;
              addr_q     <= rd_dat.addr;
              num_q      <= rd_dat.num;
              retry_q    <= '0;
              gap_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_q == GW'(GAP_CYC - 1)) begin
              tx_en_q <= 1'b1;
              state_q <= ST_ISSUE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          ST_ISSUE: begin
            timer_q <= '0;
            state_q <= ST_WAIT_TX;
          end
          ST_WAIT_TX: begin
            if (tx_done_i) begin
              state_q <= ST_WAIT_RSP;
            end
          end
          ST_WAIT_RSP: begin
            state_q <= ST_WAIT_RSP;
          end
          ST_NEXT: begin
            rr_ptr_q <= cur_slot_q;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_en_pulse_o = tx_en_q;
  assign mb_addr_o     = addr_q;
  assign mb_num_o      = num_q;
  assign fun_o         = fun_q;
  assign busy_o        = busy_q;
  assign cur_slot_o    = cur_slot_q;
  assign slot_ok_o     = slot_ok_q;
  assign slot_fail_o   = slot_fail_q;

endmodule
